// File: rtl/mul_pkg.sv
// Shared definitions for the sequential Booth multiplier: FSM states and counter sizing.
package mul_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Step counter width; kept at least one bit so W=1 still elaborates.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth step: conditional add/subtract of M, then arithmetic shift of {ACC,Q,q_1}.
module booth_step #(
  parameter int unsigned W = 16
) (
  input  logic [W:0]   acc_i,
  input  logic [W-1:0] q_i,
  input  logic         q1_i,
  input  logic [W:0]   m_i,
  output logic [W:0]   acc_o,
  output logic [W-1:0] q_o,
  output logic         q1_o
);

  logic [W:0] sum;

  always_comb begin
    sum = acc_i;
    unique case ({q_i[0], q1_i})
      2'b01:   sum = acc_i + m_i;
      2'b10:   sum = acc_i - m_i;
      default: sum = acc_i;
    endcase
    acc_o = {sum[W], sum[W:1]};
    q_o   = {sum[0], q_i[W-1:1]};
    q1_o  = q_i[0];
  end

endmodule

// File: rtl/booth_mul_seq.sv
// Sequential signed radix-2 Booth multiplier, one step per clock, start/busy/done handshake.
module booth_mul_seq
  import mul_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [W-1:0]   A,
  input  logic [W-1:0]   B,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] P
);

  localparam int unsigned CNT_W = cnt_width(W);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(W - 1);

  state_e           state_q;
  logic [W:0]       m_q;
  logic [W:0]       acc_q, acc_d;
  logic [W-1:0]     q_q, q_d;
  logic             q1_q, q1_d;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q, done_q;
  logic [2*W-1:0]   p_q;

  booth_step #(.W(W)) u_step (
    .acc_i (acc_q),
    .q_i   (q_q),
    .q1_i  (q1_q),
    .m_i   (m_q),
    .acc_o (acc_d),
    .q_o   (q_d),
    .q1_o  (q1_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      m_q     <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      q1_q    <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      p_q     <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            m_q     <= {A[W-1], A};
            q_q     <= B;
            acc_q   <= '0;
            q1_q    <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          acc_q <= acc_d;
          q_q   <= q_d;
          q1_q  <= q1_d;
          cnt_q <= cnt_q + CNT_W'(1);
          // P is loaded from the step result, so the final step is included.
          if (cnt_q == LAST_STEP) begin
            p_q     <= {acc_d[W-1:0], q_d};
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign P    = p_q;

endmodule

// File: tb/tb_booth_mul_seq.sv
// Directed bench for booth_mul_seq (W=16) with hand-computed products and latency checks.
module tb_booth_mul_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] A = '0;
  logic [15:0] B = '0;
  logic        busy;
  logic        done;
  logic [31:0] P;

  int checks = 0;
  int failures = 0;

  booth_mul_seq #(.W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .P     (P)
  );

  always #5 clk = ~clk;

  task automatic chk(input logic [63:0] obs, input logic [63:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Latency counts edges from the accepting edge through the edge that raises done.
  task automatic run_mul(input logic [15:0] a, input logic [15:0] b,
                         input logic [31:0] exp, input string tag);
    int lat;
    bit seen;
    @(negedge clk);
    A = a; B = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    seen = 1'b0;
    chk({63'd0, busy}, 64'd1, {tag, "_busy"});
    while (!seen && lat < 40) begin
      if (done) seen = 1'b1;
      else begin
        @(posedge clk); #1;
        lat++;
      end
    end
    chk({63'd0, seen}, 64'd1, {tag, "_done_seen"});
    chk(64'(lat), 64'd17, {tag, "_latency"});
    chk({32'd0, P}, {32'd0, exp}, {tag, "_P"});
    @(posedge clk); #1;
    chk({62'd0, done, busy}, 64'd0, {tag, "_after_done"});
    chk({32'd0, P}, {32'd0, exp}, {tag, "_P_held"});
  endtask

  initial begin
    int dones;
    int idx;
    int first_idx;
    int second_idx;
    logic [31:0] p_at_done;

    #2;
    chk({30'd0, busy, done}, 64'd0, "reset_busy_done");
    chk({32'd0, P}, 64'd0, "reset_P");
    @(negedge clk);
    rst_n = 1'b1;

    run_mul(16'd3,    16'd5,    32'h0000000F, "3x5");
    run_mul(16'hFFFD, 16'd5,    32'hFFFFFFF1, "m3x5");
    run_mul(16'hFF80, 16'h0002, 32'hFFFFFF00, "m128x2");
    run_mul(16'h8000, 16'h8000, 32'h40000000, "min_x_min");
    run_mul(16'h7FFF, 16'h8000, 32'hC0008000, "max_x_min");
    run_mul(16'h0000, 16'h1234, 32'h00000000, "zero_x");

    // Start pulsed mid-RUN must be ignored.
    @(negedge clk);
    A = 16'd3; B = 16'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    A = 16'd9; B = 16'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    A = 16'd7; B = 16'd7;
    dones = 0;
    p_at_done = '0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (done) begin
        dones++;
        p_at_done = P;
      end
    end
    chk(64'(dones), 64'd1, "midrun_done_count");
    chk({32'd0, p_at_done}, 64'h0F, "midrun_P");

    // Start held high: back-to-back ops, W+2 cycles apart.
    @(negedge clk);
    A = 16'd2; B = 16'd3; start = 1'b1;
    first_idx = -1;
    second_idx = -1;
    idx = 0;
    while (second_idx < 0 && idx < 60) begin
      @(posedge clk); #1;
      idx++;
      if (done) begin
        if (first_idx < 0) first_idx = idx;
        else second_idx = idx;
      end
    end
    @(negedge clk);
    start = 1'b0;
    chk(64'(first_idx), 64'd17, "held_first_done");
    chk(64'(second_idx - first_idx), 64'd18, "held_throughput");
    chk({32'd0, P}, 64'd6, "held_P");
    repeat (3) @(negedge clk);
    chk({63'd0, busy}, 64'd0, "held_idle_after");

    // Reset mid-RUN aborts immediately.
    @(negedge clk);
    A = 16'd100; B = 16'd100; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    chk({63'd0, busy}, 64'd1, "prereset_busy");
    rst_n = 1'b0;
    #1;
    chk({30'd0, busy, done}, 64'd0, "async_reset_busy_done");
    chk({32'd0, P}, 64'd0, "async_reset_P");
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done || busy) dones++;
    end
    chk(64'(dones), 64'd0, "post_reset_quiet");
    run_mul(16'd7, 16'hFFFE, 32'hFFFFFFF2, "after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
